// File: rtl/ft245_device_emu.sv
// FT245 chip-side emulator: two byte FIFOs bridging a host stream pair
// and the board's asynchronous RD#/WR# strobe interface.
module ft245_device_emu #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int RXF_HOLD = 2,
  parameter int TXE_HOLD = 2
) (
  input  logic          clock_in,
  input  logic          reset,
  inout  wire  [7:0]    io_245,
  output logic          rxf_n,
  input  logic          rd_n,
  output logic          txe_n,
  input  logic          wr_n,
  input  logic [7:0]    host_tx_data,
  input  logic          host_tx_valid,
  output logic          host_tx_ready,
  output logic [7:0]    host_rx_data,
  output logic          host_rx_valid,
  input  logic          host_rx_ready,
  output logic [AW:0]   rx_count,
  output logic [AW:0]   tx_count,
  output logic          err_rd,
  output logic          err_wr
);

  localparam int HMAX = (RXF_HOLD > TXE_HOLD) ? RXF_HOLD : TXE_HOLD;
  localparam int HW = $clog2(HMAX + 2);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    R_IDLE,
    R_DRIVE,
    R_HOLD
  } rd_st_e;

  typedef enum logic {
    W_IDLE,
    W_HOLD
  } wr_st_e;

  logic          rd_s1_q, rd_s2_q, rd_s3_q;
  logic          wr_s1_q, wr_s2_q, wr_s3_q;
  logic [7:0]    bus_s1_q, bus_s2_q;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];

  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0]   rx_count_q, rx_count_d;
  logic [AW:0]   tx_count_q, tx_count_d;
  rd_st_e        rd_st_q, rd_st_d;
  wr_st_e        wr_st_q, wr_st_d;
  logic [HW-1:0] rd_cnt_q, rd_cnt_d;
  logic [HW-1:0] wr_cnt_q, wr_cnt_d;
  logic          err_rd_q, err_rd_d;
  logic          err_wr_q, err_wr_d;

  logic rd_fall, rd_rise, wr_fall;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic rx_empty, tx_full;

  // Strobes are asynchronous; the bus sample rides alongside wr_n
  always_ff @(posedge clock_in) begin
    if (reset) begin
      rd_s1_q  <= 1'b1;
      rd_s2_q  <= 1'b1;
      rd_s3_q  <= 1'b1;
      wr_s1_q  <= 1'b1;
      wr_s2_q  <= 1'b1;
      wr_s3_q  <= 1'b1;
      bus_s1_q <= '0;
      bus_s2_q <= '0;
    end else begin
      rd_s1_q  <= rd_n;
      rd_s2_q  <= rd_s1_q;
      rd_s3_q  <= rd_s2_q;
      wr_s1_q  <= wr_n;
      wr_s2_q  <= wr_s1_q;
      wr_s3_q  <= wr_s2_q;
      bus_s1_q <= io_245;
      bus_s2_q <= bus_s1_q;
    end
  end

  assign rd_fall = rd_s3_q & ~rd_s2_q;
  assign rd_rise = ~rd_s3_q & rd_s2_q;
  assign wr_fall = wr_s3_q & ~wr_s2_q;

  assign rx_empty      = (rx_count_q == '0);
  assign tx_full       = (tx_count_q == FULL);
  assign host_tx_ready = (rx_count_q != FULL);
  assign host_rx_valid = (tx_count_q != '0);
  assign host_rx_data  = tx_mem_q[tx_rp_q];
  assign rx_push       = host_tx_valid & host_tx_ready;
  assign tx_pop        = host_rx_valid & host_rx_ready;

  assign io_245 = (rd_st_q == R_DRIVE) ? rx_mem_q[rx_rp_q] : 8'hzz;

  always_comb begin
    rd_st_d  = rd_st_q;
    rd_cnt_d = rd_cnt_q;
    rx_pop   = 1'b0;
    rxf_n    = 1'b1;
    unique case (rd_st_q)
      R_IDLE: begin
        rxf_n = rx_empty | reset;
        if (rd_fall && !rxf_n) begin
          rd_st_d = R_DRIVE;
        end
      end
      R_DRIVE: begin
        rxf_n = 1'b0;
        if (rd_rise) begin
          rx_pop   = 1'b1;
          rd_cnt_d = HW'(RXF_HOLD);
          rd_st_d  = R_HOLD;
        end
      end
      R_HOLD: begin
        if (rd_cnt_q <= HW'(1)) begin
          rd_cnt_d = '0;
          rd_st_d  = R_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q - HW'(1);
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
    err_rd_d = err_rd_q | (rd_fall & rxf_n);
  end

  always_comb begin
    wr_st_d  = wr_st_q;
    wr_cnt_d = wr_cnt_q;
    tx_push  = 1'b0;
    txe_n    = 1'b1;
    unique case (wr_st_q)
      W_IDLE: begin
        txe_n = tx_full | reset;
        if (wr_fall && !txe_n) begin
          tx_push  = 1'b1;
          wr_cnt_d = HW'(TXE_HOLD);
          wr_st_d  = W_HOLD;
        end
      end
      W_HOLD: begin
        if (wr_cnt_q <= HW'(1)) begin
          wr_cnt_d = '0;
          wr_st_d  = W_IDLE;
        end else begin
          wr_cnt_d = wr_cnt_q - HW'(1);
        end
      end
    endcase
    err_wr_d = err_wr_q | (wr_fall & txe_n);
  end

  always_comb begin
    rx_wp_d    = rx_wp_q + AW'(rx_push);
    rx_rp_d    = rx_rp_q + AW'(rx_pop);
    tx_wp_d    = tx_wp_q + AW'(tx_push);
    tx_rp_d    = tx_rp_q + AW'(tx_pop);
    rx_count_d = rx_count_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    tx_count_d = tx_count_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
  end

  always_ff @(posedge clock_in) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= host_tx_data;
    if (tx_push) tx_mem_q[tx_wp_q] <= bus_s2_q;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_count_q <= '0;
      tx_count_q <= '0;
      rd_st_q    <= R_IDLE;
      wr_st_q    <= W_IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      err_rd_q   <= 1'b0;
      err_wr_q   <= 1'b0;
    end else begin
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
      rd_st_q    <= rd_st_d;
      wr_st_q    <= wr_st_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      err_rd_q   <= err_rd_d;
      err_wr_q   <= err_wr_d;
    end
  end

  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;
  assign err_rd   = err_rd_q;
  assign err_wr   = err_wr_q;

endmodule

// File: tb/tb_ft245_device_emu.sv
// Bench for ft245_device_emu: table-driven reads, directed write/reset
// corners, and randomized stream traffic against a queue-based model.
module tb_ft245_device_emu;

  localparam int N_RD = 5;
  localparam logic [7:0] BUS_IDLE = 8'hFF;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  // undriven bus floats high
  tri1 [7:0]  io_245;
  logic [7:0] tb_drv = 8'h00;
  logic       tb_oe = 1'b0;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       rxf_n, txe_n;
  logic [7:0] host_tx_data = 8'h00;
  logic       host_tx_valid = 1'b0;
  logic       host_tx_ready;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready = 1'b0;
  logic [4:0] rx_count, tx_count;
  logic       err_rd, err_wr;

  assign io_245 = tb_oe ? tb_drv : 8'hzz;

  ft245_device_emu dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .io_245        (io_245),
    .rxf_n         (rxf_n),
    .rd_n          (rd_n),
    .txe_n         (txe_n),
    .wr_n          (wr_n),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .rx_count      (rx_count),
    .tx_count      (tx_count),
    .err_rd        (err_rd),
    .err_wr        (err_wr)
  );

  initial forever #5 clock_in = ~clock_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] exp_io;
    logic [4:0] exp_cnt;
  } rd_vec_t;

  rd_vec_t    tbl [N_RD];
  logic [7:0] rxq [$];
  logic [7:0] txq [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock_in);
    #1;
  endtask

  task automatic host_push(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    host_tx_data  = b;
    host_tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (host_tx_ready) begin
        tick;
        ok = 1'b1;
        break;
      end
      tick;
    end
    host_tx_valid = 1'b0;
    if (!ok) chk("host_push timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_pulse(input int lo, output logic [7:0] got,
                          output bit drv, output int hi);
    got = 8'h00;
    drv = 1'b0;
    hi  = 0;
    rd_n = 1'b0;
    for (int i = 0; i < lo; i++) begin
      tick;
      if (io_245 !== BUS_IDLE) begin
        drv = 1'b1;
        got = io_245;
      end
    end
    rd_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rxf_n) hi++;
    end
  endtask

  task automatic wr_pulse(input logic [7:0] d);
    tb_drv = d;
    tb_oe  = 1'b1;
    wr_n   = 1'b0;
    repeat (4) tick;
    wr_n = 1'b1;
    repeat (2) tick;
    tb_oe = 1'b0;
    repeat (2) tick;
  endtask

  task automatic wait_txe;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!txe_n) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    if (!ok) chk("txe_n wait timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] got;
    bit         drv;
    int         hi;

    tbl[0] = '{8'h3C, 8'h3C, 5'd4};
    tbl[1] = '{8'hA5, 8'hA5, 5'd3};
    tbl[2] = '{8'h00, 8'h00, 5'd2};
    tbl[3] = '{8'h81, 8'h81, 5'd1};
    tbl[4] = '{8'h5A, 8'h5A, 5'd0};

    repeat (3) tick;
    chk("reset rxf_n", 32'(rxf_n), 32'd1);
    chk("reset txe_n", 32'(txe_n), 32'd1);
    chk("reset io_245", 32'(io_245), 32'(BUS_IDLE));
    chk("reset host_tx_ready", 32'(host_tx_ready), 32'd1);
    chk("reset host_rx_valid", 32'(host_rx_valid), 32'd0);
    chk("reset rx_count", 32'(rx_count), 32'd0);
    chk("reset tx_count", 32'(tx_count), 32'd0);
    chk("reset err_rd", 32'(err_rd), 32'd0);
    chk("reset err_wr", 32'(err_wr), 32'd0);
    reset = 1'b0;
    tick;
    chk("idle txe_n", 32'(txe_n), 32'd0);
    chk("idle rxf_n", 32'(rxf_n), 32'd1);

    // table-driven board reads
    for (int i = 0; i < N_RD; i++) host_push(tbl[i].d);
    chk("rd tbl rx_count full", 32'(rx_count), 32'(N_RD));
    chk("rd tbl rxf_n low", 32'(rxf_n), 32'd0);
    for (int i = 0; i < N_RD; i++) begin
      rd_pulse(4, got, drv, hi);
      chk($sformatf("rd tbl[%0d] driven", i), 32'(drv), 32'd1);
      chk($sformatf("rd tbl[%0d] io", i), 32'(got), 32'(tbl[i].exp_io));
      chk($sformatf("rd tbl[%0d] rxf hold", i), 32'(hi >= 2), 32'd1);
      chk($sformatf("rd tbl[%0d] rx_count", i), 32'(rx_count),
          32'(tbl[i].exp_cnt));
    end
    chk("rd tbl err_rd", 32'(err_rd), 32'd0);

    // single write latency and txe_n hold window
    tb_drv = 8'h11;
    tb_oe  = 1'b1;
    wr_n   = 1'b0;
    tick;
    chk("wr1 valid early c1", 32'(host_rx_valid), 32'd0);
    tick;
    chk("wr1 valid early c2", 32'(host_rx_valid), 32'd0);
    chk("wr1 txe_n pre", 32'(txe_n), 32'd0);
    tick;
    chk("wr1 valid", 32'(host_rx_valid), 32'd1);
    chk("wr1 data", 32'(host_rx_data), 32'h11);
    chk("wr1 tx_count", 32'(tx_count), 32'd1);
    chk("wr1 txe_n hold c1", 32'(txe_n), 32'd1);
    tick;
    chk("wr1 txe_n hold c2", 32'(txe_n), 32'd1);
    tick;
    chk("wr1 txe_n release", 32'(txe_n), 32'd0);
    wr_n = 1'b1;
    repeat (2) tick;
    tb_oe = 1'b0;
    host_rx_ready = 1'b1;
    tick;
    host_rx_ready = 1'b0;
    chk("wr1 drained", 32'(tx_count), 32'd0);

    // fill TX FIFO, overflow write, ordered drain
    for (int i = 0; i < 16; i++) begin
      wait_txe;
      wr_pulse(8'(i));
    end
    chk("fill tx_count", 32'(tx_count), 32'd16);
    chk("fill txe_n", 32'(txe_n), 32'd1);
    chk("fill err_wr clear", 32'(err_wr), 32'd0);
    wr_pulse(8'hEE);
    chk("overflow err_wr", 32'(err_wr), 32'd1);
    chk("overflow tx_count", 32'(tx_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain[%0d] valid", i), 32'(host_rx_valid), 32'd1);
      chk($sformatf("drain[%0d] data", i), 32'(host_rx_data), 32'(i));
      host_rx_ready = 1'b1;
      tick;
      host_rx_ready = 1'b0;
    end
    chk("drain tx_count", 32'(tx_count), 32'd0);
    chk("drain host_rx_valid", 32'(host_rx_valid), 32'd0);
    chk("drain txe_n", 32'(txe_n), 32'd0);

    // random board writes vs random host drain
    fork
      begin : tx_writer
        logic [7:0] b;
        for (int i = 0; i < 30; i++) begin
          wait_txe;
          b = 8'($urandom);
          txq.push_back(b);
          wr_pulse(b);
          repeat ($urandom_range(0, 3)) tick;
        end
      end
      begin : tx_drainer
        int rcv;
        rcv = 0;
        for (int c = 0; c < 3000 && rcv < 30; c++) begin
          if (host_rx_valid && $urandom_range(0, 1) == 1) begin
            if (txq.size() == 0) begin
              chk("tx rand unexpected byte", 32'(host_rx_data), 32'h100);
            end else begin
              chk("tx rand data", 32'(host_rx_data), 32'(txq.pop_front()));
            end
            rcv++;
            host_rx_ready = 1'b1;
          end else begin
            host_rx_ready = 1'b0;
          end
          tick;
        end
        host_rx_ready = 1'b0;
        chk("tx rand count", 32'(rcv), 32'd30);
      end
    join
    chk("tx rand tx_count", 32'(tx_count), 32'd0);

    // host streams 0x00..0x27 while the board reads continuously
    fork
      begin : rx_pusher
        for (int i = 0; i < 40; i++) begin
          rxq.push_back(8'(i));
          host_push(8'(i));
          repeat ($urandom_range(0, 1)) tick;
        end
      end
      begin : rx_reader
        logic [7:0] g;
        bit         dv;
        int         h;
        bit         ok;
        for (int i = 0; i < 40; i++) begin
          ok = 1'b0;
          for (int w = 0; w < 100; w++) begin
            if (!rxf_n) begin
              ok = 1'b1;
              break;
            end
            tick;
          end
          if (!ok) begin
            chk("rx rand rxf_n timeout", 32'd0, 32'd1);
            break;
          end
          rd_pulse($urandom_range(3, 5), g, dv, h);
          chk("rx rand driven", 32'(dv), 32'd1);
          if (rxq.size() == 0) begin
            chk("rx rand unexpected byte", 32'(g), 32'h100);
          end else begin
            chk("rx rand data", 32'(g), 32'(rxq.pop_front()));
          end
        end
      end
    join
    chk("rx rand rx_count", 32'(rx_count), 32'd0);
    chk("rx rand err_rd", 32'(err_rd), 32'd0);

    // read strobe against an empty RX FIFO
    rd_pulse(4, got, drv, hi);
    chk("empty rd driven", 32'(drv), 32'd0);
    chk("empty rd err_rd", 32'(err_rd), 32'd1);
    chk("empty rd rx_count", 32'(rx_count), 32'd0);
    chk("empty rd rxf_n", 32'(rxf_n), 32'd1);

    // reset while the board is mid-read
    host_push(8'h77);
    host_push(8'h88);
    rd_n = 1'b0;
    repeat (3) tick;
    chk("mid rd io", 32'(io_245), 32'h77);
    reset = 1'b1;
    tick;
    chk("mid rst io", 32'(io_245), 32'(BUS_IDLE));
    chk("mid rst rxf_n", 32'(rxf_n), 32'd1);
    chk("mid rst rx_count", 32'(rx_count), 32'd0);
    chk("mid rst err_rd", 32'(err_rd), 32'd0);
    chk("mid rst err_wr", 32'(err_wr), 32'd0);
    reset = 1'b0;
    rd_n  = 1'b1;
    repeat (3) tick;
    chk("post rst rx_count", 32'(rx_count), 32'd0);
    host_push(8'h5A);
    rd_pulse(4, got, drv, hi);
    chk("post rst io", 32'(got), 32'h5A);
    chk("post rst driven", 32'(drv), 32'd1);
    chk("post rst final rx_count", 32'(rx_count), 32'd0);
    chk("post rst final err_rd", 32'(err_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ft245_device_emu.md
Name: ft245_device_emu

Overview:
Synthesizable emulator of the FTDI FT245 asynchronous FIFO chip side. It implements the opposite end of the board's FTDI bridge: it drives the bridge's RXF#/TXE# flags, responds to its RD#/WR# strobes, and owns the shared data bus during reads. Host-side traffic is a pair of valid/ready byte streams that stand in for the PC. It is used for loopback builds and as the bridge's verification partner in simulation.

Parameters:
DEPTH, 16, entries in each internal FIFO (power of two).
AW, 4, log2(DEPTH).
RXF_HOLD, 2, cycles rxf_n is forced high after each completed read.
TXE_HOLD, 2, cycles txe_n is forced high after each accepted write.

Ports:
clock_in  input  1  system clock
reset  input  1  synchronous, active-high
io_245  inout  8  shared data bus; driven only while a read strobe is active
rxf_n  output  1  low = byte available to the board
rd_n  input  1  read strobe from the board, asynchronous
txe_n  output  1  low = board may write
wr_n  input  1  write strobe from the board, asynchronous
host_tx_data  input  8  byte from the emulated PC toward the board
host_tx_valid  input  1  host_tx_data valid
host_tx_ready  output  1  RX FIFO not full
host_rx_data  output  8  byte from the board toward the emulated PC
host_rx_valid  output  1  TX FIFO not empty
host_rx_ready  input  1  host consumes host_rx_data
rx_count  output  AW+1  RX FIFO occupancy (host to board)
tx_count  output  AW+1  TX FIFO occupancy (board to host)
err_rd  output  1  sticky: rd_n fell while rxf_n was high
err_wr  output  1  sticky: wr_n fell while txe_n was high

Behaviour:
- Reset value of every output, and state forced by reset: clock_in and reset are the already-decided clock and reset (reset is synchronous, active-high). Reset empties both FIFOs and sets rxf_n=1, txe_n=1, io_245=Z (oe=0), host_tx_ready=1, host_rx_valid=0, counts=0, err_rd=0, err_wr=0, and both FSMs to idle.
- Reset mid-strobe: the partial read or write is abandoned and no pop or push occurs.
- Synchronization: rd_n and wr_n pass through 2-FF synchronizers (reset value 1). io_245 is sampled through a 2-stage register aligned with the wr_n synchronizer.
- Edge detection: edges are detected on the synchronized strobes only.
- Host push: push into the RX FIFO when host_tx_valid && host_tx_ready.
- Host pop: pop from the TX FIFO when host_rx_valid && host_rx_ready.
- host_rx_data is the TX FIFO head. It is combinational from storage and stable while host_rx_valid=1 and no pop occurs.
- Read FSM states are R_IDLE, R_DRIVE and R_HOLD:
  - R_IDLE: rxf_n = (rx_count==0). On a rd falling edge with rxf_n=0: oe=1, io_245=RX head, go to R_DRIVE. On a rd falling edge with rxf_n=1: set err_rd, no drive, stay in R_IDLE.
  - R_DRIVE: io_245 holds the head byte. On a rd rising edge: oe=0, pop RX FIFO, rxf_n=1, load the hold counter with RXF_HOLD, go to R_HOLD.
  - R_HOLD: rxf_n=1. Decrement the counter; at 0 go to R_IDLE.
- Write FSM states are W_IDLE and W_HOLD:
  - W_IDLE: txe_n = (tx_count==DEPTH). On a wr falling edge with txe_n=0: push the aligned io_245 sample, txe_n=1, load the hold counter with TXE_HOLD, go to W_HOLD. On a wr falling edge with txe_n=1: set err_wr, drop the byte.
  - W_HOLD: txe_n=1 until the counter reaches 0, then go to W_IDLE.
- Latency:
  - Host push to rxf_n low: 1 cycle, if the read FSM is in R_IDLE.
  - Raw rd_n fall to io_245 driven: 3 cycles (2 sync + 1 register).
  - Raw wr_n fall to tx_count increment: 3 cycles.
- Simultaneous events:
  - A host push and a board pop in the same cycle: both succeed and rx_count is unchanged.
  - A board push and a host pop in the same cycle: tx_count is unchanged.
  - Push to a full FIFO: refused via ready. Pop from an empty FIFO: impossible via valid.
- Pointers are AW bits and wrap modulo DEPTH. Counts saturate at 0 and DEPTH by construction.
- err_rd and err_wr clear only on reset.

Test Plan:
- Host pushes 0x3C, 0xA5; board pulses rd_n low 4 cycles twice -> io_245 shows 0x3C then 0xA5, rxf_n high ≥2 cycles after each, rx_count 2→0, err_rd=0.
- Board writes 0x11 via a wr_n fall with host_rx_ready=0 -> host_rx_valid=1, host_rx_data=0x11 3 cycles later, txe_n high exactly 2 cycles then low.
- Board writes 16 bytes 0x00..0x0F with no host drain -> tx_count=16, txe_n stays 1; a 17th wr_n fall sets err_wr=1, the byte is dropped, host drains 0x00..0x0F in order.
- rd_n falls with the RX FIFO empty -> io_245 stays Z, err_rd=1, rx_count stays 0.
- Host pushes every cycle while the board reads continuously -> no loss or duplication; 40 bytes 0x00..0x27 emerge in order across pointer wrap.
- Reset asserted while rd_n is low in R_DRIVE -> next cycle io_245=Z, rxf_n=1, rx_count=0, no pop; normal reads resume after release.
